// File: rtl/thing_stack_if.sv
// Handshake and memory-side bundle of the thing-path stack controller.
// The master modport is the upstream/memory side; the slave modport is the controller.
interface thing_stack_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              ready_lifo;
    logic [DATA_W-1:0] thing_in;
    logic [3:0]        thing_num;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              valid_lifo;
    logic              valid_fifo2;
    logic              done_thing;
    logic              done_lifo;
    logic              done_fifo2;
    logic              busy;
    logic              overflow;

    modport master (
        output ready_lifo, thing_in, thing_num,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  valid_lifo, valid_fifo2, done_thing, done_lifo, done_fifo2,
        input  busy, overflow
    );

    modport slave (
        input  ready_lifo, thing_in, thing_num,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output valid_lifo, valid_fifo2, done_thing, done_lifo, done_fifo2,
        output busy, overflow
    );
endinterface

// File: rtl/thing_stack_ctrl.sv
// Stack sequencing controller: pushes items, pops LIFO groups on ';', drains
// bottom-first on '$'. Owns the stack pointer and every memory address.
module thing_stack_ctrl #(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter int                ADDR_W = 4,
    parameter logic [DATA_W-1:0] SEMI   = 8'h3B,
    parameter logic [DATA_W-1:0] DOLLAR = 8'h24
) (
    input logic          clk,
    input logic          rst,
    thing_stack_if.slave bus
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {S_LOAD, S_POP, S_GDONE, S_FLUSH, S_END} state_e;

    state_e          state_q, state_d;
    logic [ADDR_W:0] sp_q, sp_d;
    logic [ADDR_W:0] pop_cnt_q, pop_cnt_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            vl_q, vl_d;
    logic            vf_q, vf_d;
    logic            dt_q, dt_d;
    logic            de_q, de_d;
    logic            wr_en, rd_en;
    logic [ADDR_W:0] sp_m1;
    logic [ADDR_W:0] num_ext;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic [ADDR_W:0] min_cnt(input logic [ADDR_W:0] a,
                                                input logic [ADDR_W:0] b);
        return (a < b) ? a : b;
    endfunction

    assign sp_m1   = sp_q - 1'b1;
    assign num_ext = (ADDR_W+1)'(bus.thing_num);

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        pop_cnt_d = pop_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        vl_d      = 1'b0;
        vf_d      = 1'b0;
        dt_d      = 1'b0;
        de_d      = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        case (state_q)
            S_LOAD: begin
                if (bus.ready_lifo) begin
                    if (bus.thing_in == SEMI) begin
                        pop_cnt_d = min_cnt(num_ext, sp_q);
                        state_d   = S_POP;
                    end else if (bus.thing_in == DOLLAR) begin
                        rd_ptr_d = '0;
                        state_d  = S_FLUSH;
                    end else if (sp_q < FULL) begin
                        wr_en = 1'b1;
                        sp_d  = sp_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_POP: begin
                if (pop_cnt_q != '0) begin
                    rd_en     = 1'b1;
                    rd_addr   = sp_m1[ADDR_W-1:0];
                    sp_d      = sp_m1;
                    pop_cnt_d = pop_cnt_q - 1'b1;
                    vl_d      = 1'b1;
                end else begin
                    // done_thing lands in the GDONE cycle, right after the last valid_lifo
                    dt_d    = 1'b1;
                    state_d = S_GDONE;
                end
            end
            S_GDONE: state_d = S_LOAD;
            S_FLUSH: begin
                if (rd_ptr_q < sp_q) begin
                    rd_en    = 1'b1;
                    rd_addr  = rd_ptr_q[ADDR_W-1:0];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    vf_d     = 1'b1;
                end else begin
                    sp_d    = '0;
                    de_d    = 1'b1;
                    state_d = S_END;
                end
            end
            S_END:   state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOAD;
            sp_q      <= '0;
            pop_cnt_q <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            vl_q      <= 1'b0;
            vf_q      <= 1'b0;
            dt_q      <= 1'b0;
            de_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            pop_cnt_q <= pop_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            vl_q      <= vl_d;
            vf_q      <= vf_d;
            dt_q      <= dt_d;
            de_q      <= de_d;
        end
    end

    assign bus.wr_en       = wr_en;
    assign bus.wr_addr     = sp_q[ADDR_W-1:0];
    assign bus.wr_data     = bus.thing_in;
    assign bus.rd_en       = rd_en;
    assign bus.rd_addr     = rd_addr;
    assign bus.valid_lifo  = vl_q;
    assign bus.valid_fifo2 = vf_q;
    assign bus.done_thing  = dt_q;
    assign bus.done_lifo   = de_q;
    assign bus.done_fifo2  = de_q;
    assign bus.busy        = (state_q != S_LOAD);
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_thing_stack_ctrl.sv
// Directed bench for thing_stack_ctrl with a timeline model of the stack and an
// external 1-cycle-latency register file feeding thing_out.
module tb_thing_stack_ctrl;
    localparam int MAXC = 1024;
    localparam logic [7:0] SEMI = 8'h3B;
    localparam logic [7:0] DOLLAR = 8'h24;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    thing_stack_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    thing_stack_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];
    logic [7:0] thing_out;
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_en) thing_out <= mem[bus.rd_addr];
    end

    // Expected per-cycle timeline
    logic       exp_wr [MAXC];
    logic [3:0] exp_wa [MAXC];
    logic [7:0] exp_wd [MAXC];
    logic       exp_rd [MAXC];
    logic [3:0] exp_ra [MAXC];
    logic       exp_vl [MAXC];
    logic       exp_vf [MAXC];
    logic [7:0] exp_vd [MAXC];
    logic       exp_dt [MAXC];
    logic       exp_de [MAXC];
    logic       exp_bz [MAXC];
    logic [7:0] stk [17];
    int msp = 0;
    int free_at = 0;
    int ovf_at = MAXC;

    logic [7:0] lifo_log[$];
    logic [7:0] fifo_log[$];
    int dt_cyc, dl_cyc, df_cyc, rd_cnt, wr_cnt;
    logic last_wr_en;
    logic [3:0] last_wr_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int c0);
        for (int i = c0; i < MAXC; i++) begin
            exp_wr[i] = 0; exp_wa[i] = 0; exp_wd[i] = 0; exp_rd[i] = 0; exp_ra[i] = 0;
            exp_vl[i] = 0; exp_vf[i] = 0; exp_vd[i] = 0; exp_dt[i] = 0; exp_de[i] = 0;
            exp_bz[i] = 0;
        end
    endtask

    task automatic model_apply(input int t, input logic [7:0] b, input int n);
        int nn;
        if (t < free_at) return;
        if (b == SEMI) begin
            nn = (n < msp) ? n : msp;
            for (int i = 1; i <= nn; i++) begin
                exp_rd[t+i] = 1; exp_ra[t+i] = 4'(msp - i);
                exp_vl[t+i+1] = 1; exp_vd[t+i+1] = stk[msp-i];
            end
            exp_dt[t+nn+2] = 1;
            for (int c = t + 1; c <= t + nn + 2; c++) exp_bz[c] = 1;
            free_at = t + nn + 3;
            msp -= nn;
        end else if (b == DOLLAR) begin
            for (int i = 1; i <= msp; i++) begin
                exp_rd[t+i] = 1; exp_ra[t+i] = 4'(i - 1);
                exp_vf[t+i+1] = 1; exp_vd[t+i+1] = stk[i-1];
            end
            exp_de[t+msp+2] = 1;
            for (int c = t + 1; c <= t + msp + 2; c++) exp_bz[c] = 1;
            free_at = t + msp + 3;
            msp = 0;
        end else if (msp < 16) begin
            exp_wr[t] = 1; exp_wa[t] = 4'(msp); exp_wd[t] = b;
            stk[msp] = b;
            msp++;
        end else if (ovf_at > t + 1) begin
            ovf_at = t + 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cyc < MAXC) begin
            chk("wr_en", bus.wr_en, exp_wr[cyc]);
            if (exp_wr[cyc]) begin
                chk("wr_addr", bus.wr_addr, exp_wa[cyc]);
                chk("wr_data", bus.wr_data, exp_wd[cyc]);
            end
            chk("rd_en", bus.rd_en, exp_rd[cyc]);
            if (exp_rd[cyc]) chk("rd_addr", bus.rd_addr, exp_ra[cyc]);
            chk("valid_lifo", bus.valid_lifo, exp_vl[cyc]);
            chk("valid_fifo2", bus.valid_fifo2, exp_vf[cyc]);
            if (exp_vl[cyc] || exp_vf[cyc]) chk("thing_out", thing_out, exp_vd[cyc]);
            chk("done_thing", bus.done_thing, exp_dt[cyc]);
            chk("done_lifo", bus.done_lifo, exp_de[cyc]);
            chk("done_fifo2", bus.done_fifo2, exp_de[cyc]);
            chk("busy", bus.busy, exp_bz[cyc]);
            chk("overflow", bus.overflow, cyc >= ovf_at);
            if (bus.valid_lifo) lifo_log.push_back(thing_out);
            if (bus.valid_fifo2) fifo_log.push_back(thing_out);
            if (bus.done_thing) dt_cyc = cyc;
            if (bus.done_lifo) dl_cyc = cyc;
            if (bus.done_fifo2) df_cyc = cyc;
            if (bus.rd_en) rd_cnt++;
            if (bus.wr_en) wr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_free();
        while (cyc < free_at) tick();
    endtask

    task automatic send(input logic [7:0] b, input int n, input logic rdy);
        bus.ready_lifo = rdy; bus.thing_in = b; bus.thing_num = 4'(n);
        if (rdy) model_apply(cyc, b, n);
        #1;
        last_wr_en = bus.wr_en; last_wr_addr = bus.wr_addr;
        @(posedge clk); #1;
        bus.ready_lifo = 0; bus.thing_in = 0; bus.thing_num = 0;
    endtask

    initial begin
        int t;
        clear_from(0);
        rst = 1; bus.ready_lifo = 0; bus.thing_in = 0; bus.thing_num = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0;
        free_at = cyc;
        chk("rst_busy", bus.busy, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_valid", {bus.valid_lifo, bus.valid_fifo2}, 0);
        chk("rst_done", {bus.done_thing, bus.done_lifo, bus.done_fifo2}, 0);

        // Group pop of two out of three
        send(8'h41, 0, 1); send(8'h42, 0, 1); send(8'h43, 0, 1);
        lifo_log.delete(); t = cyc;
        send(SEMI, 2, 1);
        wait_free(); tick();
        chk("t1_lifo_n", lifo_log.size(), 2);
        if (lifo_log.size() == 2) begin
            chk("t1_lifo0", lifo_log[0], 8'h43);
            chk("t1_lifo1", lifo_log[1], 8'h42);
        end
        chk("t1_done_lat", dt_cyc - t, 4);

        // Push then flush
        send(8'h44, 0, 1);
        chk("t2_push_addr", last_wr_addr, 1);
        fifo_log.delete(); t = cyc;
        send(DOLLAR, 0, 1);
        wait_free(); tick();
        chk("t2_fifo_n", fifo_log.size(), 2);
        if (fifo_log.size() == 2) begin
            chk("t2_fifo0", fifo_log[0], 8'h41);
            chk("t2_fifo1", fifo_log[1], 8'h44);
        end
        chk("t2_done_lat", dl_cyc - t, 4);
        chk("t2_done_pair", df_cyc, dl_cyc);

        // Zero-count group and underflowing group
        send(8'h31, 0, 1);
        chk("t3_push_addr", last_wr_addr, 0);
        send(8'h32, 0, 1); send(8'h33, 0, 1);
        rd_cnt = 0; t = cyc;
        send(SEMI, 0, 1);
        wait_free(); tick();
        chk("t3_zero_rd", rd_cnt, 0);
        chk("t3_zero_lat", dt_cyc - t, 2);
        send(SEMI, 1, 1);
        wait_free();
        rd_cnt = 0; t = cyc;
        send(SEMI, 5, 1);
        wait_free(); tick();
        chk("t3_under_rd", rd_cnt, 2);
        chk("t3_under_lat", dt_cyc - t, 4);

        // ready_lifo gaps and bytes while busy
        wr_cnt = 0;
        send(8'h61, 0, 1);
        send(8'h62, 0, 0);
        tick();
        send(8'h62, 0, 1);
        send(SEMI, 2, 1);
        send(8'h63, 0, 1);
        send(DOLLAR, 0, 1);
        send(8'h64, 0, 1);
        wait_free(); tick();
        chk("t5_writes", wr_cnt, 2);

        // Overflow then full flush
        for (int i = 0; i < 17; i++) send(8'(8'h60 + i), 0, 1);
        chk("t4_17th_wr_en", last_wr_en, 0);
        chk("t4_overflow", bus.overflow, 1);
        fifo_log.delete();
        send(DOLLAR, 0, 1);
        wait_free(); tick();
        chk("t4_fifo_n", fifo_log.size(), 16);
        for (int i = 0; i < fifo_log.size(); i++) chk("t4_fifo_item", fifo_log[i], 8'(8'h60 + i));
        chk("t4_ovf_sticky", bus.overflow, 1);

        // Reset in the second POP cycle
        send(8'h71, 0, 1); send(8'h72, 0, 1); send(8'h73, 0, 1);
        send(SEMI, 2, 1);
        tick();
        rst = 1;
        clear_from(cyc + 1);
        msp = 0; free_at = cyc + 1; ovf_at = MAXC;
        tick();
        rst = 0;
        chk("t6_valid", bus.valid_lifo, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_overflow", bus.overflow, 0);
        chk("t6_rd_en", bus.rd_en, 0);
        send(8'h55, 0, 1);
        chk("t6_push_en", last_wr_en, 1);
        chk("t6_push_addr", last_wr_addr, 0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
